systolic_seq_ctrl: RTL and testbench
====================================

# systolic_seq_ctrl

Sequencing controller for the 4x4 systolic-array datapath. It steps the shared SRAM bank address through all test cases and runs a fixed 17-cycle schedule per case. The schedule drives SRAM enable, accumulator clear, operand-feed strobes and the output-check window (`start_check`/`out_valid`). It sits inside `TOP` between the SRAM banks (A0..A3, B) and the PE array. It replaces ad-hoc counter logic.

## Interface
- `NUM_CASES`, 1024: cases per run; last address is NUM_CASES-1.
- `ADDR_WIDTH`, 10: width of `BankAddr`.
- `CYCLES_PER_CASE`, 17: schedule length per case (cycle index 0..16).
- `FEED_START`, 1: first feed cycle; accounts for 1-cycle SRAM read latency.
- `FEED_LEN`, 4: number of feed cycles.
- `CHECK_CYCLE`, 7: cycle index at which `start_check` pulses.
- `OUT_ROUNDS`, 8: length of the `out_valid` window, starting at CHECK_CYCLE.
- `clk` in 1: single clock, rising edge.
- `rstnSys` in 1: asynchronous, active-low reset.
- `startSys` in 1: level run-enable.
- `BankAddr` out ADDR_WIDTH: SRAM address, shared by all banks.
- `mem_en` out 1: SRAM chip select.
- `acc_clr` out 1: clears PE partial sums, one-cycle pulse.
- `feed_valid` out 1: operand skew/feed active.
- `feed_idx` out 5: cycle index within the case, 0..16.
- `start_check` out 1: one-cycle pulse marking the first valid output round.
- `out_valid` out 1: OpC3x rows are valid this cycle.
- `busy` out 1: state is RUN.
- `done` out 1: all cases completed.

## Operation
- States:
  - IDLE: all strobes low.
  - RUN: schedule active.
  - DONE: `done`=1, `mem_en`=0.
- Transitions:
  - IDLE→RUN when `startSys`=1. The case resumes at the retained `BankAddr`, with `feed_idx`=0.
  - RUN, end of case (`feed_idx`=CYCLES_PER_CASE-1):
    - If `BankAddr`=NUM_CASES-1 → DONE.
    - Else if `startSys`=0 → IDLE, with `BankAddr` incremented (pause).
    - Else stay in RUN: `BankAddr`+1, `feed_idx`←0.
  - `startSys` falling mid-case never truncates the case; it takes effect only at the case boundary.
  - DONE→IDLE when `startSys`=0; `BankAddr` clears to 0 on this transition.
- Per-case schedule, decoded from `feed_idx`:
  - `acc_clr`=1 at idx 0.
  - `feed_valid`=1 for idx FEED_START..FEED_START+FEED_LEN-1.
  - `start_check`=1 at idx CHECK_CYCLE.
  - `out_valid`=1 for idx CHECK_CYCLE..CHECK_CYCLE+OUT_ROUNDS-1.
- `mem_en`=1 throughout RUN.
- `BankAddr` is constant for all 17 cycles of a case, so the consumer can index result storage by `BankAddr` during the window.
- Elaboration check: CHECK_CYCLE+OUT_ROUNDS ≤ CYCLES_PER_CASE and FEED_START+FEED_LEN ≤ CYCLES_PER_CASE; violation is a fatal error.

## Timing
- All outputs are registered.
- Reset values: `BankAddr`=0, `feed_idx`=0, state IDLE, and every strobe/flag (`mem_en`, `acc_clr`, `feed_valid`, `start_check`, `out_valid`, `busy`, `done`) = 0.
- Start latency: `startSys` seen high at edge N → `busy`=1, `mem_en`=1, `acc_clr`=1, `feed_idx`=0 after edge N. `start_check` rises after edge N+CHECK_CYCLE.
- SRAM data for `BankAddr` is valid from idx 1; FEED_START≥1 is required.
- Back-to-back cases have no bubble: idx 16 of case k is followed directly by idx 0 of case k+1.
- Full run: NUM_CASES×CYCLES_PER_CASE cycles in RUN.
- `done` rises one edge after idx 16 of the last case; `BankAddr` holds NUM_CASES-1 while in DONE.
- `rstnSys` asserted mid-run forces reset values immediately (asynchronous), with no completion of the current case.
- Address arithmetic: ADDR_WIDTH-bit unsigned, no wrap. The increment is suppressed at NUM_CASES-1.

## Structure
- Shared package `systolic_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - default schedule constants (CYCLES_PER_CASE, FEED_START, FEED_LEN, CHECK_CYCLE, OUT_ROUNDS).
  - `FEED_IDX_W`=5.
- One sub-module, `sched_decode`: combinational idx→strobe decode, registered in the parent.
- The FSM, case counter and address counter live in the parent.

## Test plan
- Reset then `startSys`=1 held:
  - `acc_clr` at cycle 0; `start_check` at cycle 7; `out_valid` cycles 7..14.
  - `BankAddr` goes 0→1 at cycle 17.
- Full run with NUM_CASES=4:
  - 68 cycles busy, then `done`=1, `BankAddr`=3, `mem_en`=0.
  - Dropping `startSys` → IDLE with `BankAddr`=0.
- Drop `startSys` at idx 5 of case 2:
  - Case 2 completes (`out_valid` still 8 cycles), then IDLE with `BankAddr`=3.
  - Re-assert → resumes at address 3, idx 0.
- Assert `rstnSys` low at idx 10 of case 1:
  - All outputs 0 asynchronously, before the next edge; `BankAddr`=0.
- Over a full run:
  - `BankAddr` never changes while `out_valid`=1.
  - `start_check` count = NUM_CASES.
  - `feed_valid` is high exactly FEED_LEN cycles per case.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and default schedule constants for the systolic-array sequencer.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int CYCLES_PER_CASE = 17;
  localparam int FEED_START      = 1;
  localparam int FEED_LEN        = 4;
  localparam int CHECK_CYCLE     = 7;
  localparam int OUT_ROUNDS      = 8;
  localparam int FEED_IDX_W      = 5;

  typedef struct packed {
    logic acc_clr;
    logic feed_valid;
    logic start_check;
    logic out_valid;
  } sched_t;

endpackage

// File: rtl/sched_decode.sv
// Combinational decode of the per-case cycle index into schedule strobes.
module sched_decode
  import systolic_pkg::*;
#(
  parameter int FEED_START  = systolic_pkg::FEED_START,
  parameter int FEED_LEN    = systolic_pkg::FEED_LEN,
  parameter int CHECK_CYCLE = systolic_pkg::CHECK_CYCLE,
  parameter int OUT_ROUNDS  = systolic_pkg::OUT_ROUNDS
) (
  input  logic [systolic_pkg::FEED_IDX_W-1:0] i_idx,
  output sched_t                              o_sched
);

  localparam logic [FEED_IDX_W-1:0] FEED_FIRST = FEED_IDX_W'(FEED_START);
  localparam logic [FEED_IDX_W-1:0] FEED_LAST  = FEED_IDX_W'(FEED_START + FEED_LEN - 1);
  localparam logic [FEED_IDX_W-1:0] CHK_FIRST  = FEED_IDX_W'(CHECK_CYCLE);
  localparam logic [FEED_IDX_W-1:0] CHK_LAST   = FEED_IDX_W'(CHECK_CYCLE + OUT_ROUNDS - 1);

  always_comb begin
    o_sched             = '0;
    o_sched.acc_clr     = (i_idx == '0);
    o_sched.feed_valid  = (i_idx >= FEED_FIRST) && (i_idx <= FEED_LAST);
    o_sched.start_check = (i_idx == CHK_FIRST);
    o_sched.out_valid   = (i_idx >= CHK_FIRST) && (i_idx <= CHK_LAST);
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Case sequencer: walks BankAddr over all cases, running a fixed per-case
// schedule; every output is registered from the next-state values.
module systolic_seq_ctrl #(
  parameter int NUM_CASES       = 1024,
  parameter int ADDR_WIDTH      = 10,
  parameter int CYCLES_PER_CASE = systolic_pkg::CYCLES_PER_CASE,
  parameter int FEED_START      = systolic_pkg::FEED_START,
  parameter int FEED_LEN        = systolic_pkg::FEED_LEN,
  parameter int CHECK_CYCLE     = systolic_pkg::CHECK_CYCLE,
  parameter int OUT_ROUNDS      = systolic_pkg::OUT_ROUNDS
) (
  input  logic                                clk,
  input  logic                                rstnSys,
  input  logic                                startSys,
  output logic [ADDR_WIDTH-1:0]               BankAddr,
  output logic                                mem_en,
  output logic                                acc_clr,
  output logic                                feed_valid,
  output logic [systolic_pkg::FEED_IDX_W-1:0] feed_idx,
  output logic                                start_check,
  output logic                                out_valid,
  output logic                                busy,
  output logic                                done
);
  import systolic_pkg::*;

  if (CHECK_CYCLE + OUT_ROUNDS > CYCLES_PER_CASE) begin : g_chk_out
    $fatal(1, "output window does not fit in a case");
  end
  if (FEED_START + FEED_LEN > CYCLES_PER_CASE) begin : g_chk_feed
    $fatal(1, "feed window does not fit in a case");
  end
  if (FEED_START < 1) begin : g_chk_lat
    $fatal(1, "feed must start after the SRAM read latency");
  end

  localparam logic [FEED_IDX_W-1:0] LAST_IDX  = FEED_IDX_W'(CYCLES_PER_CASE - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_CASES - 1);

  state_e                  r_state, w_state_nxt;
  logic [FEED_IDX_W-1:0]   r_idx,   w_idx_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr,  w_addr_nxt;
  sched_t                  w_sched;
  logic                    w_run_nxt;

  // startSys is only sampled at case boundaries while running
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_addr_nxt  = r_addr;
    case (r_state)
      IDLE: if (startSys) begin
        w_state_nxt = RUN;
        w_idx_nxt   = '0;
      end
      RUN: if (r_idx == LAST_IDX) begin
        w_idx_nxt = '0;
        if (r_addr == LAST_ADDR) begin
          w_state_nxt = DONE;
        end else begin
          w_addr_nxt = r_addr + 1'b1;
          if (!startSys) w_state_nxt = IDLE;
        end
      end else begin
        w_idx_nxt = r_idx + 1'b1;
      end
      DONE: if (!startSys) begin
        w_state_nxt = IDLE;
        w_addr_nxt  = '0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  sched_decode #(
    .FEED_START (FEED_START),
    .FEED_LEN   (FEED_LEN),
    .CHECK_CYCLE(CHECK_CYCLE),
    .OUT_ROUNDS (OUT_ROUNDS)
  ) u_dec (
    .i_idx  (w_idx_nxt),
    .o_sched(w_sched)
  );

  assign w_run_nxt = (w_state_nxt == RUN);

  always_ff @(posedge clk or negedge rstnSys) begin
    if (!rstnSys) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_addr      <= '0;
      mem_en      <= 1'b0;
      acc_clr     <= 1'b0;
      feed_valid  <= 1'b0;
      start_check <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_addr      <= w_addr_nxt;
      mem_en      <= w_run_nxt;
      acc_clr     <= w_run_nxt & w_sched.acc_clr;
      feed_valid  <= w_run_nxt & w_sched.feed_valid;
      start_check <= w_run_nxt & w_sched.start_check;
      out_valid   <= w_run_nxt & w_sched.out_valid;
      busy        <= w_run_nxt;
      done        <= (w_state_nxt == DONE);
    end
  end

  assign BankAddr = r_addr;
  assign feed_idx = r_idx;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed + randomized bench for systolic_seq_ctrl against a cycle-level
// reference model of the case schedule (NUM_CASES reduced to 4).
module tb_systolic_seq_ctrl;
  localparam int N  = 4;
  localparam int AW = 10;
  localparam int CPC = 17;

  logic          clk = 1'b0;
  logic          rstnSys;
  logic          startSys;
  logic [AW-1:0] BankAddr;
  logic          mem_en, acc_clr, feed_valid, start_check, out_valid, busy, done;
  logic [4:0]    feed_idx;

  int checks = 0;
  int errors = 0;

  // model: mode 0 idle, 1 running, 2 finished
  int m_mode, m_addr, m_idx;

  systolic_seq_ctrl #(.NUM_CASES(N), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstnSys(rstnSys), .startSys(startSys), .BankAddr(BankAddr),
    .mem_en(mem_en), .acc_clr(acc_clr), .feed_valid(feed_valid),
    .feed_idx(feed_idx), .start_check(start_check), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = 0; m_addr = 0; m_idx = 0;
  endfunction

  function automatic void model_step(input logic s);
    if (m_mode == 0) begin
      if (s) begin m_mode = 1; m_idx = 0; end
    end else if (m_mode == 1) begin
      if (m_idx == CPC - 1) begin
        m_idx = 0;
        if (m_addr == N - 1) m_mode = 2;
        else begin
          m_addr = m_addr + 1;
          if (!s) m_mode = 0;
        end
      end else m_idx = m_idx + 1;
    end else if (!s) begin
      m_mode = 0; m_addr = 0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic run;
    logic [6:0] e;
    run = (m_mode == 1);
    e = {run, run, m_mode == 2, run && m_idx == 0, run && m_idx >= 1 && m_idx <= 4,
         run && m_idx == 7, run && m_idx >= 7 && m_idx <= 14};
    chk("strobes", 32'({busy, mem_en, done, acc_clr, feed_valid, start_check, out_valid}), 32'(e));
    chk("addr", 32'(BankAddr), 32'(m_addr));
    if (run) chk("idx", 32'(feed_idx), 32'(m_idx));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstnSys) model_step(startSys);
    #1;
    check_all();
  endtask

  initial begin
    int busy_cnt, sc_cnt, fv_cnt, moved, first_sc, first_inc, ov2, cyc;
    logic [AW-1:0] prev_addr;
    logic prev_ov;

    rstnSys = 1'b0; startSys = 1'b0; model_reset();
    repeat (3) @(posedge clk);
    #1 check_all();
    chk("rst_all_zero", 32'({BankAddr, feed_idx, mem_en, acc_clr, feed_valid, start_check,
                            out_valid, busy, done}), 32'd0);
    #3 rstnSys = 1'b1;
    tick();

    // full run with startSys held
    startSys = 1'b1;
    busy_cnt = 0; sc_cnt = 0; fv_cnt = 0; moved = 0; first_sc = -1; first_inc = -1;
    prev_ov = 1'b0; prev_addr = '0; cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      if (busy) busy_cnt++;
      if (start_check) begin sc_cnt++; if (first_sc < 0) first_sc = cyc; end
      if (feed_valid) fv_cnt++;
      if (first_inc < 0 && BankAddr == 1) first_inc = cyc;
      if (prev_ov && out_valid && BankAddr != prev_addr) moved++;
      prev_ov = out_valid; prev_addr = BankAddr; cyc++;
    end
    chk("first_start_check", 32'(first_sc), 32'd7);
    chk("first_addr_inc", 32'(first_inc), 32'd17);
    chk("busy_cycles", 32'(busy_cnt), 32'(N * CPC));
    chk("start_check_count", 32'(sc_cnt), 32'(N));
    chk("feed_valid_count", 32'(fv_cnt), 32'(N * 4));
    chk("addr_moved_in_window", 32'(moved), 32'd0);
    chk("done_flag", 32'(done), 32'd1);
    chk("done_addr", 32'(BankAddr), 32'(N - 1));
    chk("done_mem_en", 32'(mem_en), 32'd0);
    startSys = 1'b0;
    tick();
    chk("clear_addr", 32'(BankAddr), 32'd0);

    // pause at idx 5 of case 2
    startSys = 1'b1; cyc = 0;
    while (!(busy && BankAddr == 2 && feed_idx == 5) && cyc < 200) begin tick(); cyc++; end
    startSys = 1'b0; ov2 = 0; cyc = 0;
    while (busy && cyc < 200) begin
      tick();
      if (out_valid && BankAddr == 2) ov2++;
      cyc++;
    end
    chk("pause_out_valid_len", 32'(ov2), 32'd8);
    chk("pause_addr", 32'(BankAddr), 32'd3);
    chk("pause_idle", 32'(busy), 32'd0);
    startSys = 1'b1;
    tick();
    chk("resume", 32'({BankAddr, feed_idx, acc_clr}), 32'({10'd3, 5'd0, 1'b1}));
    cyc = 0;
    while (!done && cyc < 200) begin tick(); cyc++; end
    startSys = 1'b0;
    tick();

    // async reset at idx 10 of case 1
    startSys = 1'b1; cyc = 0;
    while (!(busy && BankAddr == 1 && feed_idx == 10) && cyc < 200) begin tick(); cyc++; end
    #2 rstnSys = 1'b0;
    #1;
    chk("async_rst", 32'({BankAddr, feed_idx, mem_en, acc_clr, feed_valid, start_check,
                         out_valid, busy, done}), 32'd0);
    model_reset();
    startSys = 1'b0;
    @(negedge clk) rstnSys = 1'b1;
    tick();

    // randomized run-enable
    repeat (600) begin
      startSys = ($urandom_range(0, 99) < 80);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
